// File: rtl/health_bar_anim_pkg.sv
// Shared constants for the health bar: OLED geometry, RGB565 palette, FSM states
// and the health-to-pixels scaling helper.
package health_bar_anim_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;

  localparam logic [15:0] COL_BLACK    = 16'h0000;
  localparam logic [15:0] COL_WHITE    = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW   = 16'hFFE0;
  localparam logic [15:0] COL_RED      = 16'hF800;
  localparam logic [15:0] COL_GREEN    = 16'h07E0;
  localparam logic [15:0] COL_DARK_RED = 16'h8000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2,
    S_HEAL  = 2'd3
  } anim_state_e;

  // Floor of h * il / max_h, with the product kept at 32 bits so it never wraps.
  function automatic logic [15:0] scale_len(input logic [15:0] h, input int il, input int max_h);
    logic [31:0] prod;
    prod = {16'h0000, h} * 32'(il);
    return 16'(prod / 32'(max_h));
  endfunction

endpackage

// File: rtl/health_bar_anim_if.sv
// Game-logic / pixel-mux side of the health bar: live health in, pixel query in,
// colour, ghost health and busy flag out.
interface health_bar_anim_if #(
  parameter int HW = 9
) ();
  logic          tick;
  logic          load;
  logic [HW-1:0] curr_health;
  logic [12:0]   pixel_index;
  logic [15:0]   oled_colour;
  logic [HW-1:0] shown_health;
  logic          anim_busy;

  modport master (
    output tick, load, curr_health, pixel_index,
    input  oled_colour, shown_health, anim_busy
  );

  modport slave (
    input  tick, load, curr_health, pixel_index,
    output oled_colour, shown_health, anim_busy
  );
endinterface

// File: rtl/health_bar_anim_rect_hit.sv
// Point-in-rectangle test: hit when x0 <= x < x0+len and y0 <= y < y0+h.
module health_rect_hit #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] x0_i,
  input  logic [W-1:0] y0_i,
  input  logic [W-1:0] len_i,
  input  logic [W-1:0] h_i,
  output logic         hit_o
);
  logic [W:0] x_end;
  logic [W:0] y_end;

  // One extra bit so a rectangle touching the far edge cannot wrap.
  assign x_end = {1'b0, x0_i} + {1'b0, len_i};
  assign y_end = {1'b0, y0_i} + {1'b0, h_i};

  assign hit_o = (x_i >= x0_i) && ({1'b0, x_i} < x_end) &&
                 (y_i >= y0_i) && ({1'b0, y_i} < y_end);
endmodule

// File: rtl/health_bar_anim.sv
// Animated health bar: ghost-trail FSM (hold, drain, heal), low-health flash,
// and a registered RGB565 pixel colour for the OLED mux.
module health_bar_anim
  import health_bar_anim_pkg::*;
#(
  parameter int HW          = 9,
  parameter int MAX_HEALTH  = 400,
  parameter int X_START     = 55,
  parameter int Y_START     = 2,
  parameter int BAR_LEN     = 40,
  parameter int BAR_HEIGHT  = 8,
  parameter int MIRROR      = 0,
  parameter int HOLD_TICKS  = 16,
  parameter int DRAIN_STEP  = 1,
  parameter int LOW_HEALTH  = 80,
  parameter int FLASH_TICKS = 8
) (
  input logic              clk,
  input logic              rst_n,
  health_bar_anim_if.slave bus
);
  localparam int IL  = BAR_LEN - 2;
  localparam int HCW = $clog2(HOLD_TICKS + 1);
  localparam int FCW = $clog2(FLASH_TICKS + 1);
  localparam logic [HW-1:0]  MAX_H       = HW'(MAX_HEALTH);
  localparam logic [HW-1:0]  STEP        = HW'(DRAIN_STEP);
  localparam logic [HW-1:0]  LOW_H       = HW'(LOW_HEALTH);
  localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(HOLD_TICKS);
  localparam logic [FCW-1:0] FLASH_LAST  = FCW'(FLASH_TICKS - 1);

  anim_state_e    state_q, state_d;
  logic [HW-1:0]  ghost_q, ghost_d, prev_c_q;
  logic [HW-1:0]  c, lo, hi, dn_amt, up_amt;
  logic [HCW-1:0] hold_q, hold_d;
  logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
  logic           flash_q, flash_d, low;
  logic [15:0]    colour_q, colour_d;

  assign c      = (bus.curr_health > MAX_H) ? MAX_H : bus.curr_health;
  assign low    = (c != '0) && (c <= LOW_H);
  assign dn_amt = ((ghost_q - c) < STEP) ? (ghost_q - c) : STEP;
  assign up_amt = ((c - ghost_q) < STEP) ? (c - ghost_q) : STEP;

  // State may move on any cycle; ghost and the hold countdown only advance on tick.
  always_comb begin
    state_d = state_q;
    ghost_d = ghost_q;
    hold_d  = hold_q;
    if (bus.load) begin
      state_d = S_IDLE;
      ghost_d = c;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (c < ghost_q) begin
            state_d = S_HOLD;
            hold_d  = HOLD_RELOAD;
          end else if (c > ghost_q) begin
            state_d = S_HEAL;
          end
        end
        S_HOLD: begin
          if (c > ghost_q)          state_d = S_HEAL;
          else if (c == ghost_q)    state_d = S_IDLE;
          else if (c < prev_c_q)    hold_d  = HOLD_RELOAD;
          else if (bus.tick) begin
            if (hold_q == '0) state_d = S_DRAIN;
            else              hold_d  = hold_q - HCW'(1);
          end
        end
        S_DRAIN: begin
          if (c > ghost_q)          state_d = S_HEAL;
          else if (c == ghost_q)    state_d = S_IDLE;
          else if (bus.tick) begin
            ghost_d = ghost_q - dn_amt;
            if (ghost_d == c) state_d = S_IDLE;
          end
        end
        S_HEAL: begin
          if (c < ghost_q) begin
            state_d = S_HOLD;
            hold_d  = HOLD_RELOAD;
          end else if (c == ghost_q) begin
            state_d = S_IDLE;
          end else if (bus.tick) begin
            ghost_d = ghost_q + up_amt;
            if (ghost_d == c) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    if (bus.load || !low) begin
      flash_cnt_d = '0;
      flash_d     = 1'b0;
    end else if (bus.tick) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_d     = ~flash_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FCW'(1);
      end
    end
  end

  // Pixel decode: index 0 is the border rectangle, index 1 the inner fill area.
  logic [7:0]  x_pix, y_pix, off_raw, off;
  logic [7:0]  rect_x0 [2];
  logic [7:0]  rect_y0 [2];
  logic [7:0]  rect_w  [2];
  logic [7:0]  rect_h  [2];
  logic [1:0]  rect_hit;
  logic [15:0] len_lo, len_hi;

  assign x_pix = 8'(bus.pixel_index % 13'(OLED_W));
  assign y_pix = 8'(bus.pixel_index / 13'(OLED_W));

  assign rect_x0[0] = 8'(X_START);
  assign rect_y0[0] = 8'(Y_START);
  assign rect_w[0]  = 8'(BAR_LEN);
  assign rect_h[0]  = 8'(BAR_HEIGHT);
  assign rect_x0[1] = 8'(X_START + 1);
  assign rect_y0[1] = 8'(Y_START + 1);
  assign rect_w[1]  = 8'(IL);
  assign rect_h[1]  = 8'(BAR_HEIGHT - 2);

  for (genvar gi = 0; gi < 2; gi++) begin : g_rect
    health_rect_hit #(.W(8)) u_hit (
      .x_i   (x_pix),
      .y_i   (y_pix),
      .x0_i  (rect_x0[gi]),
      .y0_i  (rect_y0[gi]),
      .len_i (rect_w[gi]),
      .h_i   (rect_h[gi]),
      .hit_o (rect_hit[gi])
    );
  end

  assign lo      = (c < ghost_q) ? c : ghost_q;
  assign hi      = (c < ghost_q) ? ghost_q : c;
  assign len_lo  = scale_len(16'(lo), IL, MAX_HEALTH);
  assign len_hi  = scale_len(16'(hi), IL, MAX_HEALTH);
  assign off_raw = x_pix - 8'(X_START + 1);
  assign off     = (MIRROR != 0) ? (8'(IL - 1) - off_raw) : off_raw;

  always_comb begin
    colour_d = COL_BLACK;
    if (rect_hit[1]) begin
      if ({8'h00, off} < len_lo)      colour_d = flash_q ? COL_WHITE : COL_YELLOW;
      else if ({8'h00, off} < len_hi) colour_d = (ghost_q > c) ? COL_RED : COL_GREEN;
      else                            colour_d = COL_DARK_RED;
    end else if (rect_hit[0]) begin
      colour_d = COL_WHITE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ghost_q     <= MAX_H;
      prev_c_q    <= MAX_H;
      hold_q      <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
      colour_q    <= COL_BLACK;
    end else begin
      state_q     <= state_d;
      ghost_q     <= ghost_d;
      prev_c_q    <= c;
      hold_q      <= hold_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      colour_q    <= colour_d;
    end
  end

  assign bus.oled_colour  = colour_q;
  assign bus.shown_health = ghost_q;
  assign bus.anim_busy    = (state_q != S_IDLE);
endmodule
